// File: rtl/spike_window_classifier_if.sv
// Handshake and data bundle between the spike window classifier and its host.
// The DUT takes the slave view; the host or testbench takes the master view.
interface spike_window_classifier_if #(
    parameter int NUM_CLASSES  = 3,
    parameter int COUNT_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 16
);
    localparam int IDX_WIDTH = $clog2(NUM_CLASSES);

    logic                              start;
    logic [WINDOW_WIDTH-1:0]           window_len;
    logic [NUM_CLASSES-1:0]            spikes;
    logic                              busy;
    logic                              result_valid;
    logic                              result_ready;
    logic [IDX_WIDTH-1:0]              winner;
    logic [COUNT_WIDTH-1:0]            winner_count;
    logic                              tie;
    logic [NUM_CLASSES*COUNT_WIDTH-1:0] spike_counts;

    modport slave (
        input  start, window_len, spikes, result_ready,
        output busy, result_valid, winner, winner_count, tie, spike_counts
    );

    modport master (
        output start, window_len, spikes, result_ready,
        input  busy, result_valid, winner, winner_count, tie, spike_counts
    );
endinterface

// File: rtl/spike_window_classifier.sv
// Counts output-layer spikes per class over a programmable window, then runs a
// one-class-per-cycle argmax and holds the winner until the consumer accepts it.
//
// state  | meaning
// IDLE   | waiting for start; last result and counts stay visible
// COUNT  | accumulating spikes, one window cycle per edge
// ARGMAX | sequential scan of the counters, lowest index wins ties
// HOLD   | result_valid high until result_ready
module spike_window_classifier #(
    parameter int NUM_CLASSES  = 3,
    parameter int COUNT_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    spike_window_classifier_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(NUM_CLASSES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_ARGMAX = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [WINDOW_WIDTH-1:0] remaining_q, remaining_d;
    logic [IDX_WIDTH-1:0]    scan_idx_q, scan_idx_d;
    logic [IDX_WIDTH-1:0]    winner_q, winner_d;
    logic [COUNT_WIDTH-1:0]  max_q, max_d;
    logic                    tie_q, tie_d;
    logic [COUNT_WIDTH-1:0]  cnt_q [NUM_CLASSES];
    logic [COUNT_WIDTH-1:0]  cnt_d [NUM_CLASSES];
    logic [COUNT_WIDTH-1:0]  cur_count;

    // Mux by compare rather than direct indexing so a non-power-of-two class
    // count never produces an out-of-range array read.
    always_comb begin
        cur_count = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx_q == IDX_WIDTH'(i)) cur_count = cnt_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        scan_idx_d  = scan_idx_q;
        winner_d    = winner_q;
        max_d       = max_q;
        tie_d       = tie_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
                    remaining_d = bus.window_len;
                    scan_idx_d  = '0;
                    state_d     = (bus.window_len == '0) ? S_ARGMAX : S_COUNT;
                end
            end
            S_COUNT: begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (bus.spikes[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
                end
                remaining_d = remaining_q - WINDOW_WIDTH'(1);
                if (remaining_q == WINDOW_WIDTH'(1)) state_d = S_ARGMAX;
            end
            S_ARGMAX: begin
                if (scan_idx_q == '0) begin
                    winner_d = '0;
                    max_d    = cur_count;
                    tie_d    = 1'b0;
                end else if (cur_count > max_q) begin
                    winner_d = scan_idx_q;
                    max_d    = cur_count;
                    tie_d    = 1'b0;
                end else if (cur_count == max_q) begin
                    tie_d    = 1'b1;
                end
                if (scan_idx_q == IDX_WIDTH'(NUM_CLASSES - 1)) begin
                    scan_idx_d = '0;
                    state_d    = S_HOLD;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
                end
            end
            S_HOLD: begin
                if (bus.result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            scan_idx_q  <= '0;
            winner_q    <= '0;
            max_q       <= '0;
            tie_q       <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            scan_idx_q  <= scan_idx_d;
            winner_q    <= winner_d;
            max_q       <= max_d;
            tie_q       <= tie_d;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = (state_q == S_HOLD);
    assign bus.winner       = winner_q;
    assign bus.winner_count = max_q;
    assign bus.tie          = tie_q;

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pack
        assign bus.spike_counts[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
    end
endmodule

// File: tb/tb_spike_window_classifier.sv
// Randomized and directed windows checked against a counting/argmax model.
module tb_spike_window_classifier;
    localparam int NC = 3;
    localparam int CW = 8;
    localparam int WW = 16;
    localparam int IW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spike_window_classifier_if #(.NUM_CLASSES(NC), .COUNT_WIDTH(CW), .WINDOW_WIDTH(WW)) bus ();

    spike_window_classifier #(.NUM_CLASSES(NC), .COUNT_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int              exp_cnt [NC];
    int              exp_win;
    int              exp_max;
    bit              exp_tie;
    logic [NC*CW-1:0] exp_vec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 random, 1 class1 always + class0 twice, 2 class0 only, 3 tie pattern
    function automatic logic [NC-1:0] pattern(input int mode, input int k);
        case (mode)
            1:       return {1'b0, 1'b1, (k <= 2)};
            2:       return 3'b001;
            3:       return (k == 1) ? 3'b111 : ((k <= 3) ? 3'b110 : 3'b000);
            default: return NC'($urandom);
        endcase
    endfunction

    task automatic run_window(input int len, input int mode, input bit noisy, input string name);
        int sum [NC];
        logic [NC-1:0] v;
        int lat;
        for (int i = 0; i < NC; i++) sum[i] = 0;

        bus.start = 1'b1;
        bus.window_len = WW'(len);
        bus.spikes = NC'($urandom);
        tick();
        bus.start = 1'b0;
        bus.window_len = WW'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end

        for (int k = 1; k <= len; k++) begin
            v = pattern(mode, k);
            bus.spikes = v;
            if (noisy) begin
                bus.start = 1'($urandom);
                bus.result_ready = 1'($urandom);
            end
            for (int i = 0; i < NC; i++) sum[i] += int'(v[i]);
            tick();
        end

        lat = len;
        while (!bus.result_valid && lat < len + 50) begin
            bus.spikes = NC'($urandom);
            if (noisy) begin
                bus.start = 1'($urandom);
                bus.result_ready = 1'($urandom);
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        bus.result_ready = 1'b0;

        for (int i = 0; i < NC; i++) exp_cnt[i] = (sum[i] > CMAX) ? CMAX : sum[i];
        exp_win = 0;
        exp_max = exp_cnt[0];
        for (int i = 1; i < NC; i++) begin
            if (exp_cnt[i] > exp_max) begin
                exp_max = exp_cnt[i];
                exp_win = i;
            end
        end
        exp_tie = 1'b0;
        for (int i = 0; i < NC; i++) if (i != exp_win && exp_cnt[i] == exp_max) exp_tie = 1'b1;
        for (int i = 0; i < NC; i++) exp_vec[i*CW +: CW] = CW'(exp_cnt[i]);

        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s result_valid_timeout: got %b want 1", name, bus.result_valid);
        end
        checks++;
        if (lat != len + NC) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, lat, len + NC);
        end
        checks++;
        if (bus.spike_counts !== exp_vec) begin
            errors++;
            $display("FAIL %s spike_counts: got %h want %h", name, bus.spike_counts, exp_vec);
        end
        checks++;
        if (bus.winner !== IW'(exp_win)) begin
            errors++;
            $display("FAIL %s winner: got %0d want %0d", name, bus.winner, exp_win);
        end
        checks++;
        if (bus.winner_count !== CW'(exp_max)) begin
            errors++;
            $display("FAIL %s winner_count: got %0d want %0d", name, bus.winner_count, exp_max);
        end
        checks++;
        if (bus.tie !== exp_tie) begin
            errors++;
            $display("FAIL %s tie: got %b want %b", name, bus.tie, exp_tie);
        end
    endtask

    task automatic handshake(input int hold_cycles, input string name);
        bus.result_ready = 1'b0;
        for (int c = 0; c < hold_cycles; c++) begin
            bus.start = 1'($urandom);
            bus.spikes = NC'($urandom);
            tick();
            checks++;
            if (bus.result_valid !== 1'b1 || bus.winner !== IW'(exp_win) ||
                bus.winner_count !== CW'(exp_max) || bus.tie !== exp_tie || bus.spike_counts !== exp_vec) begin
                errors++;
                $display("FAIL %s hold_stable c%0d: got v=%b w=%0d n=%0d t=%b c=%h want v=1 w=%0d n=%0d t=%b c=%h",
                         name, c, bus.result_valid, bus.winner, bus.winner_count, bus.tie, bus.spike_counts,
                         exp_win, exp_max, exp_tie, exp_vec);
            end
        end
        bus.start = 1'b1;
        bus.result_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake_drop: got valid=%b busy=%b want 0 0", name, bus.result_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.spike_counts !== exp_vec || bus.winner !== IW'(exp_win) ||
            bus.winner_count !== CW'(exp_max) || bus.tie !== exp_tie) begin
            errors++;
            $display("FAIL %s idle_retain: got busy=%b c=%h w=%0d n=%0d t=%b want busy=0 c=%h w=%0d n=%0d t=%b",
                     name, bus.busy, bus.spike_counts, bus.winner, bus.winner_count, bus.tie,
                     exp_vec, exp_win, exp_max, exp_tie);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.window_len = '0;
        bus.spikes = '0;
        bus.result_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.winner !== '0 ||
            bus.winner_count !== '0 || bus.tie !== 1'b0 || bus.spike_counts !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b v=%b w=%0d n=%0d t=%b c=%h want all zero",
                     bus.busy, bus.result_valid, bus.winner, bus.winner_count, bus.tie, bus.spike_counts);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_count();
        bus.start = 1'b1;
        bus.window_len = WW'(10);
        bus.spikes = 3'b111;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.spike_counts !== {CW'(4), CW'(4), CW'(4)}) begin
            errors++;
            $display("FAIL reset_mid_precheck: got busy=%b c=%h want busy=1 c=040404", bus.busy, bus.spike_counts);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.spike_counts !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got busy=%b v=%b c=%h want 0 0 0", bus.busy, bus.result_valid, bus.spike_counts);
        end
        tick();
        rst = 1'b1;
        bus.spikes = '0;
        tick();
        run_window(6, 0, 1'b0, "after_reset");
        handshake(1, "after_reset");
    endtask

    task automatic test_directed();
        run_window(5, 1, 1'b0, "w5_pattern");
        checks++;
        if (bus.spike_counts !== {CW'(0), CW'(5), CW'(2)} || bus.winner !== IW'(1) || bus.tie !== 1'b0) begin
            errors++;
            $display("FAIL w5_constants: got c=%h w=%0d t=%b want c=000502 w=1 t=0", bus.spike_counts, bus.winner, bus.tie);
        end
        handshake(6, "w5_pattern");
    endtask

    task automatic test_saturation();
        run_window(300, 2, 1'b0, "saturate");
        checks++;
        if (bus.winner_count !== CW'(255) || bus.winner !== IW'(0)) begin
            errors++;
            $display("FAIL saturate_constants: got w=%0d n=%0d want w=0 n=255", bus.winner, bus.winner_count);
        end
        handshake(1, "saturate");
    endtask

    task automatic test_tie();
        run_window(4, 3, 1'b0, "tie");
        checks++;
        if (bus.winner !== IW'(1) || bus.winner_count !== CW'(3) || bus.tie !== 1'b1) begin
            errors++;
            $display("FAIL tie_constants: got w=%0d n=%0d t=%b want w=1 n=3 t=1", bus.winner, bus.winner_count, bus.tie);
        end
        handshake(2, "tie");
    endtask

    task automatic test_zero_window();
        run_window(0, 0, 1'b0, "zero_window");
        checks++;
        if (bus.winner !== IW'(0) || bus.winner_count !== CW'(0) || bus.tie !== 1'b1) begin
            errors++;
            $display("FAIL zero_constants: got w=%0d n=%0d t=%b want w=0 n=0 t=1", bus.winner, bus.winner_count, bus.tie);
        end
        handshake(3, "zero_window");
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            run_window((r == 4) ? 270 : int'($urandom_range(0, 40)), 0, 1'b1, $sformatf("rand%0d", r));
            handshake(int'($urandom_range(0, 4)), $sformatf("rand%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_directed();
        test_saturation();
        test_tie();
        test_zero_window();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Downstream consumer of the output-layer spike vector from the fully connected spiking network.
- Counts spikes per output neuron over a programmable observation window.
- Performs a sequential argmax over the counts and presents the winning class with a valid/ready handshake.
- Provides the network's classification result to the host side or to downstream logic.

Parameters:
- NUM_CLASSES, 3, number of output neurons / spike lines (>=2).
- COUNT_WIDTH, 8, width of each per-class saturating spike counter.
- WINDOW_WIDTH, 16, width of the window length input.
- IDX_WIDTH, $clog2(NUM_CLASSES), width of the winner index (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (rst=0 resets).
- start  in  1  begin a window; honoured only in IDLE.
- window_len  in  WINDOW_WIDTH  window length in cycles (unsigned); sampled at start.
- spikes  in  NUM_CLASSES  output-layer spike vector, one bit per class.
- busy  out  1  high whenever state != IDLE.
- result_valid  out  1  result available (HOLD state).
- result_ready  in  1  consumer accepts the result.
- winner  out  IDX_WIDTH  index of the class with the highest count.
- winner_count  out  COUNT_WIDTH  count of the winning class.
- tie  out  1  another class equals the maximum count.
- spike_counts  out  NUM_CLASSES*COUNT_WIDTH  raw counters; class i occupies bits [i*COUNT_WIDTH +: COUNT_WIDTH].

Behaviour:
- States: IDLE, COUNT, ARGMAX, HOLD.
- Reset (rst=0, any state, including mid-window): state=IDLE; all counters=0; busy=0; result_valid=0; winner=0; winner_count=0; tie=0; remaining-cycle counter=0; scan index=0.
- IDLE, on an edge with start=1:
  - clear all counters;
  - latch window_len into remaining;
  - if window_len==0, go to ARGMAX, else go to COUNT.
- COUNT:
  - each edge, counter[i] += spikes[i] for every i, saturating at 2^COUNT_WIDTH-1 with no wrap;
  - remaining decrements by 1 per edge;
  - the edge that samples the last window cycle (remaining==1) also counts, then moves to ARGMAX;
  - exactly window_len cycles are sampled: edges E1..EW after start edge E0.
- ARGMAX:
  - sequential scan, one class per edge, index 0..NUM_CLASSES-1 (NUM_CLASSES edges);
  - running max initialised to class 0;
  - class k replaces the max only if count[k] > max (strictly), so the lowest index wins ties;
  - tie is set if any class k != winner has count[k] == final max, and is recomputed whenever the max changes;
  - after the last class, move to HOLD and assert result_valid.
- Latency: result_valid rises after edge E(W+NUM_CLASSES) relative to start edge E0; for W=0, after edge E(NUM_CLASSES).
- HOLD:
  - result_valid=1; winner, winner_count, tie and spike_counts are stable;
  - on an edge with result_ready=1, drop result_valid and go to IDLE;
  - result_ready outside HOLD is ignored.
- start is ignored in COUNT, ARGMAX and HOLD, including on the handshake edge; a new window needs start in IDLE.
- spikes are ignored outside COUNT.
- Outputs after handshake: winner, winner_count, tie and spike_counts retain their values in IDLE until the next start clears the counters. winner, winner_count and tie update only during ARGMAX.
- All-zero counts: winner=0, winner_count=0, tie=1.
- window_len may change freely outside the start edge.

Test Plan:
- Reset mid-COUNT (window 10, after 4 cycles of spikes=3'b111, assert rst=0) -> immediately busy=0, result_valid=0, all spike_counts=0, state IDLE; a following start behaves normally.
- window_len=5; spikes pattern class1 every cycle, class0 on 2 cycles, class2 never -> counts {0:2, 1:5, 2:0}; winner=1, winner_count=5, tie=0; result_valid rises 8 edges after the start edge.
- window_len=300, COUNT_WIDTH=8, spikes=3'b001 constant -> count0 saturates at 255 (no wrap), winner=0, winner_count=255.
- Tie: window_len=4, classes 1 and 2 each spike 3 times, class 0 once -> winner=1 (lowest index), winner_count=3, tie=1.
- window_len=0 -> no spikes counted; result_valid after 3 edges; winner=0, winner_count=0, tie=1.
- Handshake: hold result_ready=0 for 6 cycles -> outputs stable, result_valid stays 1; start pulses during HOLD/COUNT ignored; result_ready=1 -> result_valid falls on that edge, busy=0 next cycle.
